// File: rtl/ysyx_23060077_mdu_ctrl_pkg.sv
// Shared definitions for the M-extension sequencer: funct3 codes, FSM states,
// RV32M special-case constants and the multiplier sign-mode decode.
package ysyx_23060077_mdu_ctrl_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [XLEN-1:0] DIV_OVF_Q = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // {a_signed, b_signed} for the multiplier: mul/mulh 11, mulhsu 10, mulhu 00.
    function automatic logic [1:0] mul_sign_mode(input logic [2:0] f3);
        case (f3)
            F3_MULHSU: return 2'b10;
            F3_MULHU:  return 2'b00;
            default:   return 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060077_mdu_ctrl_rr_arb2.sv
// Two-way round-robin grant. The pointer moves to the other requester only
// when a response is actually handed over, so a flushed op keeps its turn.
module ysyx_23060077_rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req_valid,
    input  logic       resp_fire,
    input  logic       resp_owner,
    output logic       grant
);

    logic rr_ptr_q, rr_ptr_d;

    // Pointer side wins when it is requesting, otherwise the other side.
    always_comb begin
        grant = req_valid[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
    end

    // After a response handshake the other requester gets priority.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (resp_fire) begin
            rr_ptr_d = ~resp_owner;
        end
    end

    // Pointer register.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/ysyx_23060077_mdu_ctrl.sv
// Sequencer sharing one multiplier and one divider between two requesters.
// Handshake rule on every valid/ready pair: a transfer happens on a rising
// edge where both are high; valid stays high and its payload stable until then.
module ysyx_23060077_mdu_ctrl
    import ysyx_23060077_mdu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_is_div,
    input  logic [5:0]              req_funct3,
    input  logic [2*DATA_WIDTH-1:0] req_src1,
    input  logic [2*DATA_WIDTH-1:0] req_src2,
    output logic [1:0]              resp_valid,
    input  logic [1:0]              resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_data,
    output logic                    mul_valid,
    input  logic                    mul_ready,
    input  logic                    mul_out_valid,
    output logic [1:0]              mul_signed,
    output logic [DATA_WIDTH-1:0]   mul_a,
    output logic [DATA_WIDTH-1:0]   mul_b,
    input  logic [DATA_WIDTH-1:0]   mul_hi,
    input  logic [DATA_WIDTH-1:0]   mul_lo,
    output logic                    div_valid,
    input  logic                    div_ready,
    input  logic                    div_out_valid,
    output logic                    div_signed,
    output logic [DATA_WIDTH-1:0]   div_a,
    output logic [DATA_WIDTH-1:0]   div_b,
    input  logic [DATA_WIDTH-1:0]   div_quot,
    input  logic [DATA_WIDTH-1:0]   div_rem,
    output logic                    mul_flush,
    output logic                    div_flush,
    output state_t                  dbg_state
);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] src1_q, src1_d, src2_q, src2_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  is_div_q, is_div_d, owner_q, owner_d;
    logic [1:0]            mul_signed_q, mul_signed_d;
    logic                  div_signed_q, div_signed_d;
    logic                  mul_valid_q, mul_valid_d, div_valid_q, div_valid_d;
    logic [1:0]            resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  mul_flush_q, mul_flush_d, div_flush_q, div_flush_d;

    logic                  grant, accept, resp_fire, unit_fire, unit_done;
    logic                  sel_is_div, sel_special;
    logic [2:0]            sel_f3;
    logic [DATA_WIDTH-1:0] sel_src1, sel_src2, special_result, unit_result;

    ysyx_23060077_rr_arb2 u_arb (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .resp_fire  (resp_fire),
        .resp_owner (owner_q),
        .grant      (grant)
    );

    // Fields of the granted requester.
    assign sel_f3     = grant ? req_funct3[5:3] : req_funct3[2:0];
    assign sel_is_div = req_is_div[grant];
    assign sel_src1   = grant ? req_src1[2*DATA_WIDTH-1:DATA_WIDTH] : req_src1[DATA_WIDTH-1:0];
    assign sel_src2   = grant ? req_src2[2*DATA_WIDTH-1:DATA_WIDTH] : req_src2[DATA_WIDTH-1:0];

    assign req_ready = (state_q == ST_IDLE && !flush) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign accept    = req_ready[grant] & req_valid[grant];
    assign unit_fire = is_div_q ? (div_valid_q & div_ready) : (mul_valid_q & mul_ready);
    assign unit_done = is_div_q ? div_out_valid : mul_out_valid;
    assign resp_fire = (state_q == ST_RESP) && !flush && resp_ready[owner_q];

    // Divide by zero or signed overflow never reaches the divider.
    assign sel_special = sel_is_div && ((sel_src2 == '0) ||
                         (!sel_f3[0] && sel_src1 == DIV_OVF_Q && sel_src2 == ALL_ONES));
    assign special_result = (sel_src2 == '0) ? (sel_f3[1] ? sel_src1 : ALL_ONES)
                                             : (sel_f3[1] ? '0 : DIV_OVF_Q);

    // Pick the result word the latched funct3 asks for.
    always_comb begin
        unit_result = mul_lo;
        case (funct3_q)
            F3_MUL:                       unit_result = mul_lo;
            F3_MULH, F3_MULHSU, F3_MULHU: unit_result = mul_hi;
            F3_DIV, F3_DIVU:              unit_result = div_quot;
            default:                      unit_result = div_rem;
        endcase
    end

    // Next state; flush overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (accept)    state_d = sel_special ? ST_RESP : ST_ISSUE;
                ST_ISSUE: if (unit_fire) state_d = ST_WAIT;
                ST_WAIT:  if (unit_done) state_d = ST_RESP;
                ST_RESP:  if (resp_fire) state_d = ST_IDLE;
                default:                 state_d = ST_IDLE;
            endcase
        end
    end

    // Operand latches load only on an accepted request.
    always_comb begin
        src1_d       = src1_q;
        src2_d       = src2_q;
        funct3_d     = funct3_q;
        is_div_d     = is_div_q;
        owner_d      = owner_q;
        mul_signed_d = mul_signed_q;
        div_signed_d = div_signed_q;
        if (accept) begin
            src1_d       = sel_src1;
            src2_d       = sel_src2;
            funct3_d     = sel_f3;
            is_div_d     = sel_is_div;
            owner_d      = grant;
            mul_signed_d = mul_sign_mode(sel_f3);
            div_signed_d = ~sel_f3[0];
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_comb begin
        mul_valid_d  = (state_d == ST_ISSUE) && !is_div_d;
        div_valid_d  = (state_d == ST_ISSUE) && is_div_d;
        resp_valid_d = 2'b00;
        if (state_d == ST_RESP) begin
            resp_valid_d = owner_d ? 2'b10 : 2'b01;
        end
        resp_data_d = resp_data_q;
        if (accept && sel_special) begin
            resp_data_d = special_result;
        end else if (!flush && state_q == ST_WAIT && unit_done) begin
            resp_data_d = unit_result;
        end
        mul_flush_d = flush && (state_q == ST_ISSUE || state_q == ST_WAIT) && !is_div_q;
        div_flush_d = flush && (state_q == ST_ISSUE || state_q == ST_WAIT) && is_div_q;
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            src1_q       <= '0;
            src2_q       <= '0;
            funct3_q     <= '0;
            is_div_q     <= 1'b0;
            owner_q      <= 1'b0;
            mul_signed_q <= 2'b00;
            div_signed_q <= 1'b0;
            mul_valid_q  <= 1'b0;
            div_valid_q  <= 1'b0;
            resp_valid_q <= 2'b00;
            resp_data_q  <= '0;
            mul_flush_q  <= 1'b0;
            div_flush_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            funct3_q     <= funct3_d;
            is_div_q     <= is_div_d;
            owner_q      <= owner_d;
            mul_signed_q <= mul_signed_d;
            div_signed_q <= div_signed_d;
            mul_valid_q  <= mul_valid_d;
            div_valid_q  <= div_valid_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            mul_flush_q  <= mul_flush_d;
            div_flush_q  <= div_flush_d;
        end
    end

    // The unit not carrying the current op must stay silent while one is in flight.
    always @(posedge clock) begin
        if (!reset && (state_q == ST_ISSUE || state_q == ST_WAIT)) begin
            assert (!(is_div_q ? mul_out_valid : div_out_valid));
        end
    end

    assign mul_valid  = mul_valid_q;
    assign div_valid  = div_valid_q;
    assign mul_signed = mul_signed_q;
    assign div_signed = div_signed_q;
    assign mul_a      = src1_q;
    assign mul_b      = src2_q;
    assign div_a      = src1_q;
    assign div_b      = src2_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign mul_flush  = mul_flush_q;
    assign div_flush  = div_flush_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ysyx_23060077_mdu_ctrl.sv
// Directed bench for ysyx_23060077_mdu_ctrl: a vector table of single ops plus
// hand-written round-robin and flush sequences. The bench plays both units.
module tb_ysyx_23060077_mdu_ctrl;
    import ysyx_23060077_mdu_ctrl_pkg::*;

    localparam int W = 32;

    logic           clock, reset, flush;
    logic [1:0]     req_valid, req_ready, req_is_div, resp_valid, resp_ready;
    logic [5:0]     req_funct3;
    logic [2*W-1:0] req_src1, req_src2;
    logic [W-1:0]   resp_data;
    logic           mul_valid, mul_ready, mul_out_valid;
    logic [1:0]     mul_signed;
    logic [W-1:0]   mul_a, mul_b, mul_hi, mul_lo;
    logic           div_valid, div_ready, div_out_valid, div_signed;
    logic [W-1:0]   div_a, div_b, div_quot, div_rem;
    logic           mul_flush, div_flush;
    state_t         dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    int mul_hs = 0;
    int div_hs = 0;
    int div_vcyc = 0;

    typedef struct {
        int          side;
        logic        is_div;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic        special;
        logic [1:0]  sgn;
        int          rdly;
        int          hold;
        logic [31:0] expv;
    } vec_t;

    vec_t vecs[14];

    ysyx_23060077_mdu_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_is_div    (req_is_div),
        .req_funct3    (req_funct3),
        .req_src1      (req_src1),
        .req_src2      (req_src2),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .mul_valid     (mul_valid),
        .mul_ready     (mul_ready),
        .mul_out_valid (mul_out_valid),
        .mul_signed    (mul_signed),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_hi        (mul_hi),
        .mul_lo        (mul_lo),
        .div_valid     (div_valid),
        .div_ready     (div_ready),
        .div_out_valid (div_out_valid),
        .div_signed    (div_signed),
        .div_a         (div_a),
        .div_b         (div_b),
        .div_quot      (div_quot),
        .div_rem       (div_rem),
        .mul_flush     (mul_flush),
        .div_flush     (div_flush),
        .dbg_state     (dbg_state)
    );

    // Clock and watchdog.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: still running at %0t, required finish before 400000", $time);
        $fatal(1, "watchdog expired");
    end

    // Unit handshake counters.
    always @(posedge clock) begin
        if (mul_valid && mul_ready) mul_hs <= mul_hs + 1;
        if (div_valid && div_ready) div_hs <= div_hs + 1;
        if (div_valid) div_vcyc <= div_vcyc + 1;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        req_valid = '0; req_is_div = '0; req_funct3 = '0; req_src1 = '0; req_src2 = '0;
        resp_ready = '0;
        mul_ready = 1'b0; mul_out_valid = 1'b0; mul_hi = '0; mul_lo = '0;
        div_ready = 1'b0; div_out_valid = 1'b0; div_quot = '0; div_rem = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic drive_req(input int side, input logic is_div, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b);
        req_valid[side] = 1'b1;
        req_is_div[side] = is_div;
        req_funct3[side*3 +: 3] = f3;
        req_src1[side*W +: W] = a;
        req_src2[side*W +: W] = b;
    endtask

    // Returns the accepted side (or -1) and leaves time at the negedge after the accept edge.
    task automatic wait_accept(output int side);
        side = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((req_ready & req_valid) != 2'b00) begin
                side = req_ready[1] ? 1 : 0;
                break;
            end
            @(negedge clock);
        end
        if (side < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: no req_ready within 20 cycles, required an accept");
        end
        @(negedge clock);
    endtask

    // Plays the selected unit from the first issue cycle until its result has been delivered.
    task automatic service_unit(input logic is_div, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b, input logic [1:0] sgn, input int rdly);
        logic [63:0] sa, sb, prod;
        logic [31:0] q, r;
        check("unit_valid", is_div ? div_valid : mul_valid, 1);
        check("other_valid", is_div ? mul_valid : div_valid, 0);
        check("op_a", is_div ? div_a : mul_a, a);
        check("op_b", is_div ? div_b : mul_b, b);
        check("sign_mode", is_div ? {1'b0, div_signed} : mul_signed, sgn);
        repeat (rdly) begin
            @(negedge clock);
            check("valid_hold", is_div ? div_valid : mul_valid, 1);
        end
        if (is_div) div_ready = 1'b1; else mul_ready = 1'b1;
        @(negedge clock);
        div_ready = 1'b0;
        mul_ready = 1'b0;
        check("valid_drop", is_div ? div_valid : mul_valid, 0);
        check("state_wait", dbg_state, ST_WAIT);
        repeat (2) @(negedge clock);
        if (is_div) begin
            if (!f3[0]) begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end else begin
                q = a / b;
                r = a % b;
            end
            div_quot = q;
            div_rem = r;
            div_out_valid = 1'b1;
        end else begin
            sa = (f3 == F3_MULHU) ? {32'b0, a} : {{32{a[31]}}, a};
            sb = (f3 == F3_MULHSU || f3 == F3_MULHU) ? {32'b0, b} : {{32{b[31]}}, b};
            prod = sa * sb;
            mul_hi = prod[63:32];
            mul_lo = prod[31:0];
            mul_out_valid = 1'b1;
        end
        @(negedge clock);
        mul_out_valid = 1'b0;
        div_out_valid = 1'b0;
    endtask

    // Checks the pending response against the scoreboard, holds it, then accepts it.
    task automatic check_resp(input int side, input int hold);
        logic [W-1:0] expv;
        logic [1:0] vmask;
        expv = exp_q.pop_front();
        vmask = (side == 1) ? 2'b10 : 2'b01;
        check("resp_valid", resp_valid, vmask);
        check("resp_data", resp_data, expv);
        repeat (hold) begin
            @(negedge clock);
            check("resp_hold_valid", resp_valid, vmask);
            check("resp_hold_data", resp_data, expv);
        end
        resp_ready[side] = 1'b1;
        @(negedge clock);
        resp_ready = 2'b00;
        check("resp_done", resp_valid, 0);
        check("back_idle", dbg_state, ST_IDLE);
    endtask

    task automatic run_vec(input vec_t v);
        int acc, mhs0, dhs0, dvc0;
        mhs0 = mul_hs;
        dhs0 = div_hs;
        dvc0 = div_vcyc;
        drive_req(v.side, v.is_div, v.f3, v.a, v.b);
        exp_q.push_back(v.expv);
        wait_accept(acc);
        check("grant_side", acc, v.side);
        req_valid = 2'b00;
        if (v.special) begin
            check("special_state", dbg_state, ST_RESP);
            check("special_no_div", div_valid, 0);
            check_resp(v.side, v.hold);
            check("special_div_cycles", div_vcyc - dvc0, 0);
        end else begin
            service_unit(v.is_div, v.f3, v.a, v.b, v.sgn, v.rdly);
            check_resp(v.side, v.hold);
            check("mul_handshakes", mul_hs - mhs0, v.is_div ? 0 : 1);
            check("div_handshakes", div_hs - dhs0, v.is_div ? 1 : 0);
        end
    endtask

    initial begin
        int acc, s;
        logic [2:0]  rr_f3[2];
        logic [31:0] rr_a[2], rr_b[2], rr_exp[2];

        vecs[0]  = '{side:0, is_div:0, f3:3'b000, a:32'd7,        b:32'hFFFFFFFD, special:0, sgn:2'b11, rdly:1, hold:0, expv:32'hFFFFFFEB};
        vecs[1]  = '{side:0, is_div:1, f3:3'b101, a:32'd100,      b:32'd0,        special:1, sgn:2'b00, rdly:0, hold:1, expv:32'hFFFFFFFF};
        vecs[2]  = '{side:0, is_div:1, f3:3'b111, a:32'd100,      b:32'd0,        special:1, sgn:2'b00, rdly:0, hold:0, expv:32'h00000064};
        vecs[3]  = '{side:1, is_div:1, f3:3'b100, a:32'h80000000, b:32'hFFFFFFFF, special:1, sgn:2'b01, rdly:0, hold:0, expv:32'h80000000};
        vecs[4]  = '{side:1, is_div:1, f3:3'b110, a:32'h80000000, b:32'hFFFFFFFF, special:1, sgn:2'b01, rdly:0, hold:0, expv:32'h00000000};
        vecs[5]  = '{side:0, is_div:1, f3:3'b100, a:32'd1000,     b:32'd7,        special:0, sgn:2'b01, rdly:0, hold:5, expv:32'd142};
        vecs[6]  = '{side:1, is_div:0, f3:3'b001, a:32'hFFFFFFFF, b:32'hFFFFFFFF, special:0, sgn:2'b11, rdly:2, hold:0, expv:32'h00000000};
        vecs[7]  = '{side:0, is_div:0, f3:3'b011, a:32'hFFFFFFFF, b:32'hFFFFFFFF, special:0, sgn:2'b00, rdly:0, hold:0, expv:32'hFFFFFFFE};
        vecs[8]  = '{side:1, is_div:0, f3:3'b010, a:32'hFFFFFFFF, b:32'd2,        special:0, sgn:2'b10, rdly:0, hold:1, expv:32'hFFFFFFFF};
        vecs[9]  = '{side:0, is_div:1, f3:3'b110, a:32'hFFFFFFF9, b:32'd2,        special:0, sgn:2'b01, rdly:1, hold:0, expv:32'hFFFFFFFF};
        vecs[10] = '{side:1, is_div:1, f3:3'b111, a:32'd1000,     b:32'd7,        special:0, sgn:2'b00, rdly:0, hold:0, expv:32'd6};
        vecs[11] = '{side:0, is_div:1, f3:3'b101, a:32'h80000000, b:32'hFFFFFFFF, special:0, sgn:2'b00, rdly:0, hold:0, expv:32'h00000000};
        vecs[12] = '{side:1, is_div:1, f3:3'b100, a:32'hFFFFFFF9, b:32'd0,        special:1, sgn:2'b01, rdly:0, hold:0, expv:32'hFFFFFFFF};
        vecs[13] = '{side:1, is_div:1, f3:3'b110, a:32'hFFFFFFF9, b:32'd0,        special:1, sgn:2'b01, rdly:0, hold:0, expv:32'hFFFFFFF9};

        // Reset state.
        do_reset();
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_unit_valid", {mul_valid, div_valid}, 0);
        check("rst_flush", {mul_flush, div_flush}, 0);
        check("rst_operands", {mul_a[15:0], div_b[15:0]}, 0);

        // Single ops from the table.
        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i]);
        end

        // Flush in IDLE blocks the accept.
        drive_req(0, 1'b1, F3_DIVU, 32'd1000, 32'd7);
        flush = 1'b1;
        #1;
        check("flush_blocks_ready", req_ready, 0);
        @(negedge clock);
        flush = 1'b0;
        check("flush_idle_state", dbg_state, ST_IDLE);

        // Flush during WAIT of a divu, with a divider result landing in the same cycle.
        wait_accept(acc);
        check("flush_grant", acc, 0);
        check("flush_div_valid", div_valid, 1);
        req_valid = 2'b00;
        div_ready = 1'b1;
        @(negedge clock);
        div_ready = 1'b0;
        check("flush_in_wait", dbg_state, ST_WAIT);
        flush = 1'b1;
        div_out_valid = 1'b1;
        div_quot = 32'h12345678;
        div_rem = 32'h9ABCDEF0;
        @(negedge clock);
        flush = 1'b0;
        div_out_valid = 1'b0;
        check("div_flush_pulse", div_flush, 1);
        check("mul_flush_quiet", mul_flush, 0);
        check("flush_no_resp", resp_valid, 0);
        check("flush_to_idle", dbg_state, ST_IDLE);

        // Pointer must still favour requester 0 after the flushed op.
        drive_req(0, 1'b0, F3_MUL, 32'd7, 32'hFFFFFFFD);
        drive_req(1, 1'b0, F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        #1;
        check("post_flush_ready", req_ready, 2'b01);
        exp_q.push_back(32'hFFFFFFEB);
        wait_accept(acc);
        check("post_flush_grant", acc, 0);
        req_valid = 2'b00;
        check("div_flush_one_cycle", div_flush, 0);
        check("post_flush_resp_quiet", resp_valid, 0);
        service_unit(1'b0, F3_MUL, 32'd7, 32'hFFFFFFFD, 2'b11, 0);
        check_resp(0, 0);

        // Flush in RESP drops the pending response.
        drive_req(1, 1'b1, F3_DIVU, 32'd100, 32'd0);
        wait_accept(acc);
        req_valid = 2'b00;
        check("resp_flush_pre", resp_valid, 2'b10);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("resp_flush_drop", resp_valid, 0);
        check("resp_flush_idle", dbg_state, ST_IDLE);
        check("resp_flush_no_unit_flush", {mul_flush, div_flush}, 0);

        // Both requesters held valid after reset: grants alternate 0,1,0,1.
        do_reset();
        rr_f3[0] = F3_MULHU; rr_a[0] = 32'hFFFFFFFF; rr_b[0] = 32'hFFFFFFFF; rr_exp[0] = 32'hFFFFFFFE;
        rr_f3[1] = F3_MUL;   rr_a[1] = 32'd7;        rr_b[1] = 32'hFFFFFFFD; rr_exp[1] = 32'hFFFFFFEB;
        drive_req(0, 1'b0, rr_f3[0], rr_a[0], rr_b[0]);
        drive_req(1, 1'b0, rr_f3[1], rr_a[1], rr_b[1]);
        for (int k = 0; k < 4; k++) begin
            s = k % 2;
            wait_accept(acc);
            check("rr_grant", acc, s);
            exp_q.push_back(rr_exp[s]);
            service_unit(1'b0, rr_f3[s], rr_a[s], rr_b[s], (s == 0) ? 2'b00 : 2'b11, 0);
            check_resp(s, 0);
        end
        req_valid = 2'b00;

        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
